// File: rtl/regfile_scoreboard.sv
// Register file with two combinational read ports, one write port, optional
// register-0 hardwiring, write-to-read bypass and a per-register pending bit.
module regfile_scoreboard #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int ZERO_REG   = 1,
    parameter int BYPASS     = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] rd_addr1,
    input  logic                  rd_en1,
    output logic [DATA_WIDTH-1:0] rd_data1,
    output logic                  rd_busy1,
    input  logic [ADDR_WIDTH-1:0] rd_addr2,
    input  logic                  rd_en2,
    output logic [DATA_WIDTH-1:0] rd_data2,
    output logic                  rd_busy2,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  issue_en,
    input  logic [ADDR_WIDTH-1:0] issue_addr,
    input  logic                  flush,
    output logic                  stall
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regs [DEPTH];
    logic [DEPTH-1:0]      pending;
    logic                  wr_eff;
    logic                  issue_eff;

    function automatic logic is_zero(input logic [ADDR_WIDTH-1:0] a);
        return (ZERO_REG != 0) && (a == '0);
    endfunction

    function automatic logic bypass_hit(input logic [ADDR_WIDTH-1:0] a);
        return (BYPASS != 0) && wr_en && (wr_addr == a);
    endfunction

    // Outputs are forced quiet while reset is held so a bypassed write
    // cannot leak through during reset.
    function automatic logic [DATA_WIDTH-1:0] read_data(input logic [ADDR_WIDTH-1:0] a);
        if (!rst || is_zero(a)) return '0;
        if (bypass_hit(a)) return wr_data;
        return regs[a];
    endfunction

    function automatic logic read_busy(input logic [ADDR_WIDTH-1:0] a);
        if (!rst || is_zero(a) || bypass_hit(a)) return 1'b0;
        return pending[a];
    endfunction

    always_comb begin
        wr_eff    = wr_en && !is_zero(wr_addr);
        issue_eff = issue_en && !is_zero(issue_addr);
        rd_data1  = read_data(rd_addr1);
        rd_data2  = read_data(rd_addr2);
        rd_busy1  = read_busy(rd_addr1);
        rd_busy2  = read_busy(rd_addr2);
        stall     = (rd_en1 && rd_busy1) || (rd_en2 && rd_busy2);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) regs[ADDR_WIDTH'(i)] <= '0;
            pending <= '0;
        end else begin
            if (wr_eff) regs[wr_addr] <= wr_data;
            // Issue is applied after the write-clear so a new producer wins.
            if (flush) begin
                pending <= '0;
            end else begin
                if (wr_eff)    pending[wr_addr]    <= 1'b0;
                if (issue_eff) pending[issue_addr] <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard: a vector table on the default
// instance plus short sequences for ZERO_REG=0, BYPASS=0, a narrow build and reset.
module tb_regfile_scoreboard;
    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  rd_addr1, rd_addr2, wr_addr, issue_addr;
    logic        rd_en1, rd_en2, wr_en, issue_en, flush;
    logic [31:0] wr_data;

    logic [31:0] a_data1, a_data2, b_data1, b_data2, c_data1, c_data2;
    logic        a_busy1, a_busy2, a_stall, b_busy1, b_busy2, b_stall;
    logic        c_busy1, c_busy2, c_stall;

    logic [2:0]  s_rd_addr1, s_rd_addr2, s_wr_addr, s_issue_addr;
    logic        s_rd_en1, s_rd_en2, s_wr_en, s_issue_en, s_flush;
    logic [15:0] s_wr_data, s_data1, s_data2;
    logic        s_busy1, s_busy2, s_stall;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    regfile_scoreboard dut_a (
        .clk(clk), .rst(rst),
        .rd_addr1(rd_addr1), .rd_en1(rd_en1), .rd_data1(a_data1), .rd_busy1(a_busy1),
        .rd_addr2(rd_addr2), .rd_en2(rd_en2), .rd_data2(a_data2), .rd_busy2(a_busy2),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .issue_en(issue_en), .issue_addr(issue_addr), .flush(flush), .stall(a_stall)
    );

    regfile_scoreboard #(.ZERO_REG(0)) dut_b (
        .clk(clk), .rst(rst),
        .rd_addr1(rd_addr1), .rd_en1(rd_en1), .rd_data1(b_data1), .rd_busy1(b_busy1),
        .rd_addr2(rd_addr2), .rd_en2(rd_en2), .rd_data2(b_data2), .rd_busy2(b_busy2),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .issue_en(issue_en), .issue_addr(issue_addr), .flush(flush), .stall(b_stall)
    );

    regfile_scoreboard #(.BYPASS(0)) dut_c (
        .clk(clk), .rst(rst),
        .rd_addr1(rd_addr1), .rd_en1(rd_en1), .rd_data1(c_data1), .rd_busy1(c_busy1),
        .rd_addr2(rd_addr2), .rd_en2(rd_en2), .rd_data2(c_data2), .rd_busy2(c_busy2),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .issue_en(issue_en), .issue_addr(issue_addr), .flush(flush), .stall(c_stall)
    );

    regfile_scoreboard #(.DATA_WIDTH(16), .ADDR_WIDTH(3)) dut_d (
        .clk(clk), .rst(rst),
        .rd_addr1(s_rd_addr1), .rd_en1(s_rd_en1), .rd_data1(s_data1), .rd_busy1(s_busy1),
        .rd_addr2(s_rd_addr2), .rd_en2(s_rd_en2), .rd_data2(s_data2), .rd_busy2(s_busy2),
        .wr_en(s_wr_en), .wr_addr(s_wr_addr), .wr_data(s_wr_data),
        .issue_en(s_issue_en), .issue_addr(s_issue_addr), .flush(s_flush), .stall(s_stall)
    );

    typedef struct {
        logic        wr_en;
        logic [4:0]  wr_addr;
        logic [31:0] wr_data;
        logic        issue_en;
        logic [4:0]  issue_addr;
        logic        flush;
        logic [4:0]  a1;
        logic        e1;
        logic [4:0]  a2;
        logic        e2;
        logic [31:0] d1;
        logic        b1;
        logic [31:0] d2;
        logic        b2;
        logic        st;
    } vec_t;

    vec_t vt [16];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic idle();
        wr_en = 1'b0; wr_addr = 5'd0; wr_data = 32'h0;
        issue_en = 1'b0; issue_addr = 5'd0; flush = 1'b0;
        rd_en1 = 1'b0; rd_en2 = 1'b0; rd_addr1 = 5'd0; rd_addr2 = 5'd0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        //              wr  waddr  wdata          iss  iaddr  fl    a1    e1    a2     e2    d1             b1    d2             b2    st
        vt[0]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd31, 1'b1, 32'h0,        1'b0, 32'h0,        1'b0, 1'b0};
        vt[1]  = '{1'b1, 5'd1, 32'hFFFFFFFF, 1'b0, 5'd0, 1'b0, 5'd1, 1'b1, 5'd2,  1'b1, 32'hFFFFFFFF, 1'b0, 32'h0,        1'b0, 1'b0};
        vt[2]  = '{1'b1, 5'd3, 32'h12345678, 1'b0, 5'd0, 1'b0, 5'd1, 1'b1, 5'd3,  1'b1, 32'hFFFFFFFF, 1'b0, 32'h12345678, 1'b0, 1'b0};
        vt[3]  = '{1'b1, 5'd0, 32'h0FFFFFFF, 1'b1, 5'd0, 1'b0, 5'd0, 1'b1, 5'd3,  1'b1, 32'h0,        1'b0, 32'h12345678, 1'b0, 1'b0};
        vt[4]  = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd7, 1'b0, 5'd0, 1'b1, 5'd7,  1'b1, 32'h0,        1'b0, 32'h0,        1'b0, 1'b0};
        vt[5]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 5'd1,  1'b0, 32'h0,        1'b1, 32'hFFFFFFFF, 1'b0, 1'b1};
        vt[6]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 1'b0, 5'd7, 1'b0, 5'd7,  1'b0, 32'h0,        1'b1, 32'h0,        1'b1, 1'b0};
        vt[7]  = '{1'b1, 5'd7, 32'hA5A5A5A5, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 5'd7,  1'b1, 32'hA5A5A5A5, 1'b0, 32'hA5A5A5A5, 1'b0, 1'b0};
        vt[8]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 5'd3,  1'b1, 32'hA5A5A5A5, 1'b0, 32'h12345678, 1'b0, 1'b0};
        vt[9]  = '{1'b1, 5'd9, 32'h11112222, 1'b1, 5'd9, 1'b0, 5'd9, 1'b1, 5'd0,  1'b1, 32'h11112222, 1'b0, 32'h0,        1'b0, 1'b0};
        vt[10] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 1'b0, 5'd9, 1'b1, 5'd9,  1'b1, 32'h11112222, 1'b1, 32'h11112222, 1'b1, 1'b1};
        vt[11] = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd4, 1'b0, 5'd4, 1'b1, 5'd9,  1'b0, 32'h0,        1'b0, 32'h11112222, 1'b1, 1'b0};
        vt[12] = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd6, 1'b0, 5'd4, 1'b1, 5'd6,  1'b1, 32'h0,        1'b1, 32'h0,        1'b0, 1'b1};
        vt[13] = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd8, 1'b1, 5'd4, 1'b1, 5'd6,  1'b1, 32'h0,        1'b1, 32'h0,        1'b1, 1'b1};
        vt[14] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 1'b0, 5'd4, 1'b1, 5'd6,  1'b1, 32'h0,        1'b0, 32'h0,        1'b0, 1'b0};
        vt[15] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 1'b0, 5'd8, 1'b1, 5'd9,  1'b1, 32'h0,        1'b0, 32'h11112222, 1'b0, 1'b0};

        rst = 1'b0;
        idle();
        s_rd_addr1 = 3'd0; s_rd_addr2 = 3'd0; s_wr_addr = 3'd0; s_issue_addr = 3'd0;
        s_rd_en1 = 1'b0; s_rd_en2 = 1'b0; s_wr_en = 1'b0; s_issue_en = 1'b0;
        s_flush = 1'b0; s_wr_data = 16'h0;

        // Reset state across every address
        for (int i = 0; i < 32; i++) begin
            rd_addr1 = 5'(i); rd_addr2 = 5'(31 - i); rd_en1 = 1'b1; rd_en2 = 1'b1;
            #1;
            chk($sformatf("rst_data1[%0d]", i), a_data1, 32'h0);
            chk($sformatf("rst_busy1[%0d]", i), 32'(a_busy1), 32'h0);
            chk($sformatf("rst_stall[%0d]", i), 32'(a_stall), 32'h0);
        end
        idle();
        @(negedge clk);
        rst = 1'b1;
        step();

        for (int i = 0; i < 16; i++) begin
            wr_en = vt[i].wr_en; wr_addr = vt[i].wr_addr; wr_data = vt[i].wr_data;
            issue_en = vt[i].issue_en; issue_addr = vt[i].issue_addr; flush = vt[i].flush;
            rd_addr1 = vt[i].a1; rd_en1 = vt[i].e1; rd_addr2 = vt[i].a2; rd_en2 = vt[i].e2;
            #1;
            chk($sformatf("v%0d_data1", i), a_data1, vt[i].d1);
            chk($sformatf("v%0d_busy1", i), 32'(a_busy1), 32'(vt[i].b1));
            chk($sformatf("v%0d_data2", i), a_data2, vt[i].d2);
            chk($sformatf("v%0d_busy2", i), 32'(a_busy2), 32'(vt[i].b2));
            chk($sformatf("v%0d_stall", i), 32'(a_stall), 32'(vt[i].st));
            step();
        end
        idle();

        // ZERO_REG=0 instance kept the write to register 0
        rd_en1 = 1'b1; rd_addr1 = 5'd0; rd_addr2 = 5'd0; rd_en2 = 1'b1;
        #1;
        chk("zr_off_data1", b_data1, 32'h0FFFFFFF);
        chk("zr_off_data2", b_data2, 32'h0FFFFFFF);
        chk("zr_off_busy", 32'({b_busy1, b_busy2, b_stall}), 32'h0);
        chk("zr_on_data1", a_data1, 32'h0);
        step();

        // BYPASS=0: busy persists through the writeback cycle
        idle();
        issue_en = 1'b1; issue_addr = 5'd7;
        step();
        idle();
        rd_addr1 = 5'd7; rd_en1 = 1'b1; rd_addr2 = 5'd7;
        #1;
        chk("nb_busy1_pend", 32'(c_busy1), 32'h1);
        chk("nb_busy2_pend", 32'(c_busy2), 32'h1);
        chk("nb_stall_pend", 32'(c_stall), 32'h1);
        step();
        wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h5A5A5A5A;
        #1;
        chk("nb_data1_wb", c_data1, 32'hA5A5A5A5);
        chk("nb_stall_wb", 32'(c_stall), 32'h1);
        chk("byp_stall_wb", 32'(a_stall), 32'h0);
        chk("byp_data2_wb", a_data2, 32'h5A5A5A5A);
        step();
        wr_en = 1'b0;
        #1;
        chk("nb_stall_after", 32'(c_stall), 32'h0);
        chk("nb_busy2_after", 32'(c_busy2), 32'h0);
        chk("nb_data2_after", c_data2, 32'h5A5A5A5A);

        // Narrow instance: 16-bit data, 8 registers
        s_wr_en = 1'b1; s_wr_addr = 3'd7; s_wr_data = 16'hBEEF;
        s_rd_addr1 = 3'd7; s_rd_en1 = 1'b1; s_rd_addr2 = 3'd6; s_rd_en2 = 1'b1;
        #1;
        chk("narrow_bypass", 32'(s_data1), 32'h0000BEEF);
        step();
        s_wr_en = 1'b0; s_rd_addr2 = 3'd7;
        #1;
        chk("narrow_data1", 32'(s_data1), 32'h0000BEEF);
        chk("narrow_data2", 32'(s_data2), 32'h0000BEEF);
        chk("narrow_busy", 32'({s_busy1, s_busy2, s_stall}), 32'h0);

        // Asynchronous reset mid-run
        idle();
        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF;
        step();
        idle();
        rd_addr1 = 5'd5; rd_en1 = 1'b1;
        #1;
        chk("pre_rst_data", a_data1, 32'hDEADBEEF);
        rst = 1'b0;
        #1;
        chk("async_rst_data", a_data1, 32'h0);
        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hCAFEF00D;
        issue_en = 1'b1; issue_addr = 5'd5;
        #1;
        chk("rst_hold_data", a_data1, 32'h0);
        chk("rst_hold_stall", 32'(a_stall), 32'h0);
        step();
        idle();
        rd_addr1 = 5'd5; rd_en1 = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        step();
        chk("post_rst_data", a_data1, 32'h0);
        chk("post_rst_busy", 32'(a_busy1), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
- Parametrised successor to the MIPS register file: 2 combinational read ports, 1 synchronous write port.
- Adds optional register-0 hardwiring, write-to-read bypass, and a per-register pending (scoreboard) bit.
- Issue/decode sets a register's pending bit when an instruction targeting it is dispatched; writeback clears it. The block raises `stall` when decode would read a register whose result has not yet been written.
- Sits between decode (read and issue side) and writeback (write side).

Parameters:
- DATA_WIDTH, 32, register width in bits.
- ADDR_WIDTH, 5, register address width; DEPTH = 2**ADDR_WIDTH registers.
- ZERO_REG, 1, 1 = register 0 reads 0, ignores writes, and is never pending; 0 = register 0 is ordinary.
- BYPASS, 1, 1 = same-cycle write data is forwarded to reads and satisfies pending; 0 = reads see only stored contents.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous reset, active-low.
- rd_addr1  input  ADDR_WIDTH  read port 1 address.
- rd_en1  input  1  decode actually uses operand 1 (qualifies stall).
- rd_data1  output  DATA_WIDTH  read port 1 data (combinational).
- rd_busy1  output  1  operand 1 is pending and not satisfied this cycle.
- rd_addr2  input  ADDR_WIDTH  read port 2 address.
- rd_en2  input  1  decode actually uses operand 2.
- rd_data2  output  DATA_WIDTH  read port 2 data (combinational).
- rd_busy2  output  1  operand 2 is pending and not satisfied this cycle.
- wr_en  input  1  writeback enable.
- wr_addr  input  ADDR_WIDTH  writeback destination.
- wr_data  input  DATA_WIDTH  writeback data.
- issue_en  input  1  instruction with a destination register dispatched this cycle.
- issue_addr  input  ADDR_WIDTH  destination of the dispatched instruction.
- flush  input  1  pipeline flush; clears all pending bits.
- stall  output  1  (rd_en1 & rd_busy1) | (rd_en2 & rd_busy2).

Behaviour:
- Storage: DEPTH x DATA_WIDTH registers plus a DEPTH-bit pending vector.
- Reset (rst=0, asynchronous, immediate): all registers 0 and all pending bits 0. While reset is held: rd_data* show 0, rd_busy* = 0, stall = 0. Reset during an in-flight write aborts that write. The release edge performs no update.
- Write: at posedge, if wr_en, reg[wr_addr] <= wr_data.
  - With ZERO_REG=1 and wr_addr=0 the write is dropped.
  - The write is not blocked by stall or flush.
- Read (combinational): rd_dataN = reg[rd_addrN], with these overrides:
  - ZERO_REG=1 and rd_addrN=0 -> 0 (highest priority).
  - Otherwise, BYPASS=1 and wr_en and wr_addr==rd_addrN -> wr_data.
- Effective write-clear condition: wr_en and wr_addr not dropped by ZERO_REG.
- Pending update at posedge, evaluated in this priority order:
  1. flush=1: all pending bits <= 0; issue_en in the same cycle is ignored.
  2. Else, if the effective write-clear condition holds: pending[wr_addr] <= 0.
  3. Then, if issue_en and not (ZERO_REG and issue_addr=0): pending[issue_addr] <= 1. Issue wins over write on the same address, because the new producer supersedes the old one.
- Busy (combinational): rd_busyN = pending[rd_addrN], except:
  - Forced 0 when ZERO_REG and rd_addrN=0.
  - Forced 0 when BYPASS and wr_en and wr_addr==rd_addrN (the result arrives this cycle).
  - With BYPASS=0, busy remains asserted in the writeback cycle and clears the cycle after.
- Same register on both read ports: both see identical data and busy.
- Issue and read of the same register in the same cycle: busy reflects only the pre-edge pending bit. An instruction does not stall on its own destination.
- Latency:
  - Write visible to a non-bypassed read 1 cycle after the edge.
  - Pending set visible 1 cycle after the issue edge.
- No overflow or wrap conditions: addresses are full-range, and DEPTH must equal 2**ADDR_WIDTH.

Test Plan:
- Reset, then read all 32 addresses -> all rd_data = 0, busy = 0, stall = 0. Assert rst=0 mid-simulation after writing reg5 = 0xDEADBEEF -> reg5 reads 0 immediately, with no clock needed.
- Write reg1 = 0xFFFFFFFF at one edge; next cycle, rd_addr1=1 -> rd_data1 = 0xFFFFFFFF. With BYPASS=1, set rd_addr2=3 in the same cycle as wr_en, wr_addr=3, wr_data=0x12345678 -> rd_data2 = 0x12345678 before the edge.
- ZERO_REG=1: write reg0 = 0x0FFFFFFF and issue_addr=0 -> reg0 reads 0 and busy stays 0. Instantiate with ZERO_REG=0 -> reg0 reads 0x0FFFFFFF.
- Issue reg7; next cycle rd_addr1=7, rd_en1=1 -> rd_busy1=1, stall=1. Repeat with rd_en1=0 -> stall=0. Write reg7 = 0xA5A5A5A5:
  - BYPASS=1: stall drops in the writeback cycle.
  - BYPASS=0: stall drops one cycle later.
- Same edge, issue_en and wr_en both on reg9 -> pending[9] = 1 afterwards, so a subsequent read of reg9 shows busy.
- Issue reg4 and reg6, then flush=1 together with issue_en on reg8 -> regs 4, 6 and 8 all not busy afterwards. Issue a parametrised instance with DATA_WIDTH=16, ADDR_WIDTH=3, then write/read reg7 = 0xBEEF -> readback 0xBEEF.
